// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
package booth_pkg;

  localparam int BOOTH_N = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/booth_multiplier_if.sv
// Request/response bundle for booth_multiplier; the master issues operands, the slave multiplies.
// Handshake: start is taken only while the slave is idle (busy=0, done=0); a taken start is
// answered by exactly one done pulse, and product is valid from that cycle until the next done.
interface booth_multiplier_if #(
  parameter int N = booth_pkg::BOOTH_N
);
  logic           start;
  logic [N-1:0]   multiplicand;
  logic [N-1:0]   multiplier;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  modport master (
    output start,
    output multiplicand,
    output multiplier,
    input  busy,
    input  done,
    input  product
  );

  modport slave (
    input  start,
    input  multiplicand,
    input  multiplier,
    output busy,
    output done,
    output product
  );

endinterface

// File: rtl/and2.sv
// Two-input AND cell.
module and2 (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a & b;
endmodule

// File: rtl/booth_addsub.sv
// W-bit ripple adder/subtractor: sum = a + (b ^ {W{sub}}) + sub; the final carry is dropped.
module booth_addsub #(
  parameter int W = 9
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum
);
  logic [W-1:0] b_x;
  logic [W-1:0] carry;
  logic         carry_unused;

  assign carry[0] = sub;

  for (genvar i = 0; i < W; i++) begin : g_bit
    xor2 u_inv (.a(b[i]), .b(sub), .y(b_x[i]));
    if (i == W - 1) begin : g_msb
      fa u_fa (.a(a[i]), .b(b_x[i]), .cin(carry[i]), .sum(sum[i]), .cout(carry_unused));
    end else begin : g_lsb
      fa u_fa (.a(a[i]), .b(b_x[i]), .cin(carry[i]), .sum(sum[i]), .cout(carry[i+1]));
    end
  end
endmodule

// File: rtl/fa.sv
// One-bit full adder built from library cells: sum = a^b^cin, cout = majority(a, b, cin).
module fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  logic ab;
  logic ac;
  logic bc;

  xor3 u_sum (.a(a),  .b(b),  .c(cin), .y(sum));
  and2 u_ab  (.a(a),  .b(b),  .y(ab));
  and2 u_ac  (.a(a),  .b(cin), .y(ac));
  and2 u_bc  (.a(b),  .b(cin), .y(bc));
  or3  u_co  (.a(ab), .b(ac), .c(bc),  .y(cout));
endmodule

// File: rtl/or3.sv
// Three-input OR cell.
module or3 (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic y
);
  assign y = a | b | c;
endmodule

// File: rtl/xor2.sv
// Two-input XOR cell.
module xor2 (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a ^ b;
endmodule

// File: rtl/xor3.sv
// Three-input XOR cell.
module xor3 (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic y
);
  assign y = a ^ b ^ c;
endmodule

// File: rtl/booth_multiplier.sv
// Sequential signed radix-2 Booth multiplier: N-bit x N-bit -> 2N-bit, one recoding step per clock.
module booth_multiplier
  import booth_pkg::*;
#(
  parameter int N = BOOTH_N
) (
  input  logic              clk,
  input  logic              reset,
  booth_multiplier_if.slave bus,
  output state_t            dbg_state
);
  localparam int CW = $clog2(N + 1);

  state_t         state_q;
  logic [N:0]     a_q;
  logic [N-1:0]   q_q;
  logic           q1_q;
  logic [N:0]     m_q;
  logic [CW-1:0]  cnt_q;
  logic [2*N-1:0] product_q;

  logic           do_add;
  logic           do_sub;
  logic [N:0]     sum;
  logic [N:0]     a_next;
  logic [N:0]     a_sh;
  logic [N-1:0]   q_sh;

  // Booth recoding of the current multiplier bit pair {Q[0], q_1}.
  assign do_add = ~q_q[0] & q1_q;
  assign do_sub =  q_q[0] & ~q1_q;

  booth_addsub #(.W(N + 1)) u_addsub (
    .a   (a_q),
    .b   (m_q),
    .sub (do_sub),
    .sum (sum)
  );

  assign a_next = (do_add | do_sub) ? sum : a_q;

  // Arithmetic right shift of {A, Q, q_1}: A's sign bit is replicated, A[0] moves into Q.
  assign a_sh = {a_next[N], a_next[N:1]};
  assign q_sh = {a_next[0], q_q[N-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      q_q       <= '0;
      q1_q      <= 1'b0;
      m_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q     <= '0;
            q_q     <= bus.multiplier;
            q1_q    <= 1'b0;
            m_q     <= {bus.multiplicand[N-1], bus.multiplicand};
            cnt_q   <= CW'(N);
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q   <= a_sh;
          q_q   <= q_sh;
          q1_q  <= q_q[0];
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            product_q <= {a_sh[N-1:0], q_sh};
            state_q   <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = (state_q == RUN);
  assign bus.done    = (state_q == DONE);
  assign bus.product = product_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_booth_multiplier.sv
// Bench for booth_multiplier at N=8 (directed, corner and random vectors) and N=4 (exhaustive).
module tb_booth_multiplier;
  import booth_pkg::*;

  logic   clk = 1'b0;
  logic   reset = 1'b1;
  logic   mon_en = 1'b0;
  state_t dbg8;
  state_t dbg4;

  int checks = 0;
  int errors = 0;

  booth_multiplier_if #(.N(8)) bus8 ();
  booth_multiplier_if #(.N(4)) bus4 ();

  booth_multiplier #(.N(8)) u_dut8 (.clk(clk), .reset(reset), .bus(bus8), .dbg_state(dbg8));
  booth_multiplier #(.N(4)) u_dut4 (.clk(clk), .reset(reset), .bus(bus4), .dbg_state(dbg4));

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mul8(input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] x;
    logic signed [15:0] y;
    x = 16'(signed'(a));
    y = 16'(signed'(b));
    return 16'(x * y);
  endfunction

  function automatic logic [7:0] mul4(input logic [3:0] a, input logic [3:0] b);
    logic signed [7:0] x;
    logic signed [7:0] y;
    x = 8'(signed'(a));
    y = 8'(signed'(b));
    return 8'(x * y);
  endfunction

  // ---------------- N=8 behavioural model ----------------
  // phase 0 = idle, 1..8 = multiplying, 9 = result cycle
  int          m_phase = 0;
  logic [15:0] m_pend = '0;
  logic [15:0] m_prod = '0;
  logic [15:0] exp8_q[$];
  logic [7:0]  exp4_q[$];

  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0;
      m_prod  = '0;
      exp8_q.delete();
      exp4_q.delete();
    end else if (m_phase == 0) begin
      if (bus8.start) begin
        m_phase = 1;
        m_pend  = mul8(bus8.multiplicand, bus8.multiplier);
        exp8_q.push_back(m_pend);
      end
    end else if (m_phase == 9) begin
      m_phase = 0;
    end else begin
      m_phase++;
      if (m_phase == 9) m_prod = m_pend;
    end
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      check("n8 busy", bus8.busy, (m_phase >= 1 && m_phase <= 8));
      check("n8 done", bus8.done, (m_phase == 9));
      check("n8 product held", bus8.product, m_prod);
      if (bus8.done) begin
        if (exp8_q.size() == 0) check("n8 unexpected done", bus8.done, 1'b0);
        else check("n8 product at done", bus8.product, exp8_q.pop_front());
      end
      if (bus4.done) begin
        if (exp4_q.size() == 0) check("n4 unexpected done", bus4.done, 1'b0);
        else check("n4 product at done", bus4.product, exp4_q.pop_front());
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [15:0] lit,
                      input string name);
    int n;
    int busy_n;
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.multiplicand = a;
    bus8.multiplier = b;
    @(negedge clk);
    bus8.start = 1'b0;
    bus8.multiplicand = 8'($urandom);
    bus8.multiplier = 8'($urandom);
    n = 0;
    busy_n = 0;
    while (!bus8.done && n < 20) begin
      if (bus8.busy) busy_n++;
      @(negedge clk);
      n++;
    end
    check({name, " latency"}, n, 8);
    check({name, " busy cycles"}, busy_n, 8);
    check({name, " product"}, bus8.product, lit);
    @(negedge clk);
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b);
    int n;
    @(negedge clk);
    bus4.start = 1'b1;
    bus4.multiplicand = a;
    bus4.multiplier = b;
    exp4_q.push_back(mul4(a, b));
    @(negedge clk);
    bus4.start = 1'b0;
    n = 0;
    while (!bus4.done && n < 12) begin
      @(negedge clk);
      n++;
    end
    check("n4 latency", n, 4);
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    int last;
    int pulses;

    bus8.start = 1'b0;
    bus8.multiplicand = '0;
    bus8.multiplier = '0;
    bus4.start = 1'b0;
    bus4.multiplicand = '0;
    bus4.multiplier = '0;

    repeat (3) @(negedge clk);
    check("reset busy", bus8.busy, 1'b0);
    check("reset done", bus8.done, 1'b0);
    check("reset product", bus8.product, 16'h0000);
    check("reset state", dbg8, IDLE);
    reset = 1'b0;
    mon_en = 1'b1;

    // model pins: hand-computed results
    check("model 3x-4", mul8(8'd3, 8'hFC), 16'hFFF4);
    check("model -128x-128", mul8(8'h80, 8'h80), 16'h4000);

    run8(8'd3,  8'hFC, 16'hFFF4, "3x-4");
    run8(8'h80, 8'h80, 16'h4000, "-128x-128");
    run8(8'h80, 8'h7F, 16'hC080, "-128x127");
    run8(8'h7F, 8'h7F, 16'h3F01, "127x127");
    run8(8'h00, 8'hFF, 16'h0000, "0x-1");
    run8(8'hFF, 8'hFF, 16'h0001, "-1x-1");
    run8(8'h7F, 8'h80, 16'hC080, "127x-128");

    // start held high: only accepted in IDLE, done every 10 cycles
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.multiplicand = 8'd5;
    bus8.multiplier = 8'hFD;
    last = -1;
    pulses = 0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (bus8.done) begin
        if (last >= 0) check("held start gap", c - last, 10);
        check("held start product", bus8.product, 16'hFFF1);
        last = c;
        pulses++;
      end
    end
    check("held start pulses", pulses, 4);
    bus8.start = 1'b0;
    repeat (15) @(negedge clk);

    // reset during RUN step 4
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.multiplicand = 8'd7;
    bus8.multiplier = 8'd9;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort state", dbg8, IDLE);
    check("abort busy", bus8.busy, 1'b0);
    check("abort done", bus8.done, 1'b0);
    check("abort product", bus8.product, 16'h0000);
    reset = 1'b0;
    repeat (15) @(negedge clk);

    run8(8'd7, 8'd9, 16'h003F, "7x9 after abort");

    // random N=8 pairs against signed arithmetic
    for (int i = 0; i < 300; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      run8(ra, rb, mul8(ra, rb), "random");
    end

    // exhaustive N=4
    check("model4 -8x-8", mul4(4'h8, 4'h8), 8'h40);
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run4(4'(a), 4'(b));
      end
    end

    repeat (3) @(negedge clk);
    check("n8 queue drained", exp8_q.size(), 0);
    check("n4 queue drained", exp4_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
